hazard_ctrl: RTL

- Pipeline sequencing controller for the 5-stage core.
- Decides each cycle whether PC, IF_ID, ID_EX and EX_MEM advance, hold or take a bubble. Sources are load-use hazards, taken branches and jumps resolved in ID, instruction-memory stalls, and multi-cycle multiplies occupying EX.
- Drives the IF_ID hold/flush inputs, PC write enable, ID_EX bubble/hold, and the EX_MEM bubble. Keeps saturating stall and flush performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_sat_counter.sv | 19 +
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared core definitions: FSM state encodings, the IF_ID NOP word and the zero register.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MUL   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INST = 32'hFC000000;
  localparam logic [4:0]  ZERO_REG = 5'd0;

  // A write to the zero register never creates a dependence.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != ZERO_REG) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk_i) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: decides per cycle whether PC, IF_ID, ID_EX and EX_MEM
// advance, hold or take a bubble, and counts stall and redirect cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  input  logic             branch_i,
  input  logic             jump_i,
  input  logic             ex_mul_i,
  input  logic             imem_stall_i,
  output logic             pc_write_o,
  output logic             ifid_hold_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             idex_hold_o,
  output logic             exmem_bubble_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int MC_W = $clog2(MUL_LAT) + 1;

  state_e          state_q, state_d;
  logic [MC_W-1:0] mul_cnt_q, mul_cnt_d;
  logic            mul_start;
  logic            freeze;
  logic            load_use;
  logic            redirect;
  logic            redirect_taken;

  // DRAIN is deliberately excluded: the multiply still sitting in EX must not re-trigger.
  assign mul_start = (MUL_LAT > 1) && ex_mul_i && (state_q == RUN);
  assign freeze    = (state_q == MUL) || mul_start;
  assign load_use  = idex_memread_i &&
                     (reg_match(idex_rt_i, ifid_rs_i) ||
                      (ifid_uses_rt_i && reg_match(idex_rt_i, ifid_rt_i)));
  assign redirect  = branch_i || jump_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    mul_cnt_d      = mul_cnt_q;
    pc_write_o     = 1'b0;
    ifid_hold_o    = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    idex_hold_o    = 1'b0;
    exmem_bubble_o = 1'b0;
    redirect_taken = 1'b0;
    if (rst_i) begin
      ifid_flush_o   = 1'b1;
      idex_bubble_o  = 1'b1;
      exmem_bubble_o = 1'b1;
      state_d        = RUN;
      mul_cnt_d      = '0;
    end else if (freeze) begin
      ifid_hold_o    = 1'b1;
      idex_hold_o    = 1'b1;
      exmem_bubble_o = 1'b1;
      if (state_q == RUN) begin
        if (MUL_LAT > 2) begin
          state_d   = MUL;
          mul_cnt_d = MC_W'(MUL_LAT - 2);
        end else begin
          state_d = DRAIN;
        end
      end else begin
        mul_cnt_d = mul_cnt_q - MC_W'(1);
        if (mul_cnt_q == MC_W'(1)) begin
          state_d = DRAIN;
        end
      end
    end else begin
      if (state_q == DRAIN) begin
        state_d = RUN;
      end
      if (load_use) begin
        ifid_hold_o   = 1'b1;
        idex_bubble_o = 1'b1;
      end else if (redirect) begin
        pc_write_o     = 1'b1;
        ifid_flush_o   = 1'b1;
        redirect_taken = 1'b1;
      end else if (imem_stall_i) begin
        ifid_flush_o = 1'b1;
      end else begin
        pc_write_o = 1'b1;
      end
    end
  end

  assign state_o = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clear (rst_i),
    .inc   (!rst_i && !pc_write_o),
    .count (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clear (rst_i),
    .inc   (redirect_taken),
    .count (flush_cnt_o)
  );

endmodule
